sd_cic_decimator: RTL and testbench

- Sinc3 (3rd-order CIC) decimation filter directly downstream of the sigma-delta oversampling modulator.
- Consumes the modulator's 1-bit output stream at the oversampled rate.
- Produces one signed PCM word per OSR input bits, with a valid/ready handshake toward the sample consumer.
- Internal arithmetic is modular (two's-complement wrap), per standard CIC practice.

---
 rtl/sd_cic_decimator.sv | 181 ++++++++++++++++++
 tb/tb_sd_cic_decimator.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_cic_decimator.sv
// sd_cic_decimator: sinc3 CIC decimator for a 1-bit sigma-delta stream.
// Define SD_CIC_PCM16_EN for a rounded, saturated 16-bit output (+1 clk).
module sd_cic_decimator #(
    parameter  int LOG2_OSR = 6,
    localparam int ACC_W    = 3 * LOG2_OSR + 1,
`ifdef SD_CIC_PCM16_EN
    localparam int OUT_W    = 16
`else
    localparam int OUT_W    = ACC_W
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    bit_in,
    input  logic                    bit_valid,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    input  logic                    dout_ready,
    output logic                    overrun,
    input  logic                    overrun_clr,
    output logic                    settled
);

    localparam logic [LOG2_OSR-1:0] PH_ONE  = LOG2_OSR'(1);
    localparam logic [LOG2_OSR-1:0] PH_LAST = '1;
    localparam logic [ACC_W-1:0]    MID     = {2'b01, {(ACC_W-2){1'b0}}};

    logic [ACC_W-1:0]    i1, i2, i3;
    logic [ACC_W-1:0]    i1_nx, i2_nx, i3_nx;
    logic [LOG2_OSR-1:0] phase;
    logic                tick;
    logic                decim_vld;
    logic [ACC_W-1:0]    decim;
    logic [ACC_W-1:0]    d1, d2, d3;
    logic [ACC_W-1:0]    c1, c2, c3;
    logic [1:0]          discard;
    logic                comb_fire;
    logic [ACC_W-1:0]    comb_val;
    logic                load;
    logic [OUT_W-1:0]    load_val;

    // Next integrator values; each stage adds the freshly updated stage before it.
    always_comb begin
        i1_nx = i1 + {{(ACC_W-1){1'b0}}, bit_in};
        i2_nx = i2 + i1_nx;
        i3_nx = i3 + i2_nx;
    end

    // Integrators and phase move only on accepted bits; tick flags a frame's last bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            i1    <= '0;
            i2    <= '0;
            i3    <= '0;
            phase <= '0;
            tick  <= 1'b0;
        end else begin
            tick <= bit_valid && (phase == PH_LAST);
            if (bit_valid) begin
                i1    <= i1_nx;
                i2    <= i2_nx;
                i3    <= i3_nx;
                phase <= phase + PH_ONE;
            end
        end
    end

    // Capture I3 one clock after the frame ends, regardless of later bit gaps.
    always_ff @(posedge clk) begin
        if (reset) begin
            decim     <= '0;
            decim_vld <= 1'b0;
        end else begin
            decim_vld <= tick;
            if (tick) begin
                decim <= i3;
            end
        end
    end

    // Comb chain at the decimated rate; result recentred so mid-scale reads as zero.
    always_comb begin
        c1        = decim - d1;
        c2        = c1 - d2;
        c3        = c2 - d3;
        comb_val  = c3 - MID;
        comb_fire = decim_vld && (discard == 2'd2);
    end

    // Comb delays advance per sample; the first two results only prime the combs.
    always_ff @(posedge clk) begin
        if (reset) begin
            d1      <= '0;
            d2      <= '0;
            d3      <= '0;
            discard <= '0;
        end else if (decim_vld) begin
            d1 <= decim;
            d2 <= c1;
            d3 <= c2;
            if (discard != 2'd2) begin
                discard <= discard + 2'd1;
            end
        end
    end

`ifdef SD_CIC_PCM16_EN
    localparam int SH = ACC_W - 17;

    logic                    pcm_vld;
    logic signed [OUT_W-1:0] pcm_sat;
    logic signed [OUT_W-1:0] pcm_q;
    int                      pcm_sc;

    // Scale so that +/- full scale lands on the 16-bit rails; round half up.
    if (SH > 0) begin : g_down
        always_comb begin
            pcm_sc = int'(signed'(comb_val));
            pcm_sc = (pcm_sc + (1 <<< (SH - 1))) >>> SH;
        end
    end else begin : g_up
        always_comb begin
            pcm_sc = int'(signed'(comb_val));
            pcm_sc = pcm_sc <<< (-SH);
        end
    end

    // Clamp; positive full scale is one LSB beyond the 16-bit range.
    always_comb begin
        pcm_sat = pcm_sc[15:0];
        if (pcm_sc > 32767) begin
            pcm_sat = 16'sh7fff;
        end else if (pcm_sc < -32768) begin
            pcm_sat = 16'sh8000;
        end
    end

    // Extra register stage for the round/saturate path.
    always_ff @(posedge clk) begin
        if (reset) begin
            pcm_vld <= 1'b0;
            pcm_q   <= '0;
        end else begin
            pcm_vld <= comb_fire;
            if (comb_fire) begin
                pcm_q <= pcm_sat;
            end
        end
    end

    assign load     = pcm_vld;
    assign load_val = pcm_q;
`else
    assign load     = comb_fire;
    assign load_val = comb_val;
`endif

    // Output register with valid/ready handshake and sticky overwrite flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            overrun    <= 1'b0;
            settled    <= 1'b0;
        end else begin
            if (load) begin
                dout       <= load_val;
                dout_valid <= 1'b1;
                settled    <= 1'b1;
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
            end
            if (load && dout_valid && !dout_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sd_cic_decimator.sv
// tb_sd_cic_decimator: table-driven sinc3 decimator bench with a
// direct-convolution reference model and a cycle-timed scoreboard.
`timescale 1ns/1ps
module tb_sd_cic_decimator;

`ifdef SD_CIC_PCM16_EN
    localparam int OUT_W = 16;
    localparam int LAT   = 3;
    localparam int FS_P  = 32767;
    localparam int FS_N  = -32768;
`else
    localparam int OUT_W = 19;
    localparam int LAT   = 2;
    localparam int FS_P  = 131072;
    localparam int FS_N  = -131072;
`endif
    localparam int OSR  = 64;
    localparam int NTAP = 3 * (OSR - 1) + 1;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    bit_in = 1'b0;
    logic                    bit_valid = 1'b0;
    logic                    dout_ready = 1'b1;
    logic                    overrun_clr = 1'b0;
    logic signed [OUT_W-1:0] dout;
    logic                    dout_valid;
    logic                    overrun;
    logic                    settled;

    sd_cic_decimator #(.LOG2_OSR(6)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .overrun    (overrun),
        .overrun_clr(overrun_clr),
        .settled    (settled)
    );

    always #5 clk = ~clk;

    typedef struct {
        int exp;
        int due;
    } sb_t;

    typedef struct {
        int mode;
        bit gap;
        int frames;
        bit has_exp;
        int exp;
    } vec_t;

    sb_t  sb[$];
    int   hist[$];
    int   h[NTAP];
    int   nacc = 0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic prev_valid = 1'b0;
    vec_t vt[6];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    function automatic int map_out(input int c3);
        int v;
        v = c3 - 131072;
`ifdef SD_CIC_PCM16_EN
        v = (v + 2) >>> 2;
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
`endif
        return v;
    endfunction

    // reference: sinc3 as a direct FIR over the accepted bit history
    task automatic accept(input logic b);
        int s;
        hist.push_back(b ? 1 : 0);
        nacc++;
        if ((nacc % OSR == 0) && (nacc >= 3 * OSR)) begin
            s = 0;
            for (int j = 0; j < NTAP; j++) s += h[j] * hist[nacc - 1 - j];
            sb.push_back('{map_out(s), cyc + 1 + LAT});
        end
    endtask

    task automatic drive_bit(input logic b);
        @(negedge clk);
        bit_in    = b;
        bit_valid = 1'b1;
        accept(b);
    endtask

    task automatic idle();
        @(negedge clk);
        bit_valid = 1'b0;
        bit_in    = 1'($urandom_range(0, 1));
    endtask

    task automatic idles(input int n);
        for (int k = 0; k < n; k++) idle();
    endtask

    task automatic run_bits(input int mode, input bit gap, input int n);
        logic b;
        for (int k = 0; k < n; k++) begin
            case (mode)
                0:       b = 1'b0;
                1:       b = 1'b1;
                2:       b = (nacc % 2 == 0);
                default: b = 1'($urandom_range(0, 1));
            endcase
            drive_bit(b);
            if (gap) idle();
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset       = 1'b1;
        bit_valid   = 1'b0;
        overrun_clr = 1'b0;
        sb.delete();
        hist.delete();
        nacc = 0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout"}, int'(dout), 0);
        check({tag, "_valid"}, int'(dout_valid), 0);
        check({tag, "_overrun"}, int'(overrun), 0);
        check({tag, "_settled"}, int'(settled), 0);
    endtask

    // scoreboard: every expected sample must appear exactly on its due cycle
    always @(negedge clk) begin
        if (!reset) begin
            if (sb.size() > 0 && sb[0].due <= cyc) begin
                check("sb_latency", cyc, sb[0].due);
                check("sb_valid", int'(dout_valid), 1);
                check("sb_dout", int'(dout), sb[0].exp);
                void'(sb.pop_front());
            end else if (!prev_valid) begin
                check("spurious_valid", int'(dout_valid), 0);
            end
        end
        prev_valid <= dout_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < NTAP; k++) h[k] = 0;
        for (int a = 0; a < OSR; a++)
            for (int b = 0; b < OSR; b++)
                for (int c = 0; c < OSR; c++)
                    h[a + b + c]++;

        vt[0] = '{1, 1'b0, 3, 1'b1, FS_P};
        vt[1] = '{0, 1'b0, 4, 1'b1, FS_N};
        vt[2] = '{2, 1'b0, 5, 1'b1, 0};
        vt[3] = '{1, 1'b1, 3, 1'b1, FS_P};
        vt[4] = '{3, 1'b0, 4, 1'b0, 0};
        vt[5] = '{2, 1'b1, 4, 1'b1, 0};

        for (int v = 0; v < 6; v++) begin
            dout_ready = 1'b1;
            do_reset();
            check_zero("vec_reset");
            run_bits(vt[v].mode, vt[v].gap, vt[v].frames * OSR);
            idles(LAT + 2);
            if (vt[v].has_exp) check("vec_final_dout", int'(dout), vt[v].exp);
            check("vec_settled", int'(settled), 1);
            check("vec_overrun", int'(overrun), 0);
            check("vec_consumed", int'(dout_valid), 0);
        end

        // first-valid timing, overwrite, clear, same-edge handshake
        dout_ready = 1'b0;
        do_reset();
        run_bits(1, 1'b0, 3 * OSR - 1);
        idles(3);
        check("pre_valid", int'(dout_valid), 0);
        check("pre_settled", int'(settled), 0);
        drive_bit(1'b1);
        idles(LAT);
        check("early_valid", int'(dout_valid), 0);
        idle();
        check("first_valid", int'(dout_valid), 1);
        check("first_settled", int'(settled), 1);
        check("first_dout", int'(dout), FS_P);
        check("first_overrun", int'(overrun), 0);

        run_bits(1, 1'b0, OSR);
        idles(LAT + 1);
        check("ovr_set", int'(overrun), 1);
        check("ovr_valid", int'(dout_valid), 1);
        @(negedge clk);
        overrun_clr = 1'b1;
        @(negedge clk);
        overrun_clr = 1'b0;
        check("ovr_clr", int'(overrun), 0);
        check("ovr_clr_valid", int'(dout_valid), 1);

        run_bits(1, 1'b0, OSR);
        idles(LAT - 1);
        idle();
        dout_ready = 1'b1;
        idle();
        check("same_edge_overrun", int'(overrun), 0);
        check("same_edge_valid", int'(dout_valid), 1);
        idle();
        check("handshake_drop", int'(dout_valid), 0);
        dout_ready = 1'b0;

        run_bits(1, 1'b0, OSR);
        idles(LAT + 1);
        check("f6_valid", int'(dout_valid), 1);
        check("f6_overrun", int'(overrun), 0);
        run_bits(1, 1'b0, OSR);
        idles(LAT - 1);
        idle();
        overrun_clr = 1'b1;
        idle();
        overrun_clr = 1'b0;
        check("set_beats_clr", int'(overrun), 1);

        // reset in the middle of frame 5
        do_reset();
        run_bits(1, 1'b0, 4 * OSR + 40);
        idle();
        check("mid_pre_valid", int'(dout_valid), 1);
        check("mid_pre_overrun", int'(overrun), 1);
        do_reset();
        check_zero("mid_reset");
        run_bits(1, 1'b0, 3 * OSR - 1);
        idles(4);
        check("mid_post_wait", int'(dout_valid), 0);
        drive_bit(1'b1);
        idles(LAT + 1);
        check("mid_post_valid", int'(dout_valid), 1);
        check("mid_post_dout", int'(dout), FS_P);

        idles(4);
        check("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
